// File: rtl/spi_cmd_ctrl_pkg.sv
// Shared types and field constants for the SPI command controller.
package spi_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    ISSUE,
    DRAIN
  } state_t;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int CNT_HI = 15;
  localparam int CNT_LO = 0;

  localparam logic [31:0] ADDR_STEP = 32'd4;

endpackage

// File: rtl/spi_cmd_ctrl_word_deser.sv
// SPI front end: input synchronisers, sck/scs edge detection and a 32-bit MSB-first deserialiser.
module spi_word_deser #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scs_i,
  input  logic        sck_i,
  input  logic        sdi_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        cs_fall_o,
  output logic        cs_rise_o
);

  logic [SYNC_STAGES-1:0] scs_sync_q, scs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   scs_prev_q, scs_prev_d;
  logic                   sck_prev_q, sck_prev_d;
  logic [4:0]             bit_cnt_q, bit_cnt_d;
  logic [31:0]            shift_q, shift_d;
  logic [31:0]            word_q, word_d;
  logic                   word_valid_q, word_valid_d;

  logic scs_s, sck_s, sdi_s, sck_rise, cs_rise, cs_fall;

  assign scs_s    = scs_sync_q[SYNC_STAGES-1];
  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = scs_s & ~scs_prev_q;
  assign cs_fall  = ~scs_s & scs_prev_q;

  always_comb begin
    scs_sync_d   = {scs_sync_q[SYNC_STAGES-2:0], scs_i};
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck_i};
    sdi_sync_d   = {sdi_sync_q[SYNC_STAGES-2:0], sdi_i};
    scs_prev_d   = scs_s;
    sck_prev_d   = sck_s;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (cs_rise) begin
      bit_cnt_d = '0;
      shift_d   = '0;
    end else if (!scs_s && sck_rise) begin
      shift_d   = {shift_q[30:0], sdi_s};
      // 5-bit counter wraps to 0 after the 32nd bit on its own
      bit_cnt_d = bit_cnt_q + 5'd1;
      if (bit_cnt_q == 5'd31) begin
        word_d       = shift_d;
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scs_sync_q   <= '1;
      sck_sync_q   <= '0;
      sdi_sync_q   <= '0;
      scs_prev_q   <= 1'b1;
      sck_prev_q   <= 1'b0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      scs_sync_q   <= scs_sync_d;
      sck_sync_q   <= sck_sync_d;
      sdi_sync_q   <= sdi_sync_d;
      scs_prev_q   <= scs_prev_d;
      sck_prev_q   <= sck_prev_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;
  assign cs_fall_o    = cs_fall;
  assign cs_rise_o    = cs_rise;

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder issuing burst writes on a req/gnt bus; the request stays up, with stable address/data, until granted.
// Optional error counter output err_cnt_o is enabled by defining SPI_CMD_CTRL_ERRCNT_EN.
module spi_cmd_ctrl
  import spi_cmd_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] OP_WRITE    = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        scs_i,
  input  logic        sck_i,
  input  logic        sdi_i,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  output logic        busy_o,
  output state_t      state_o,
`ifdef SPI_CMD_CTRL_ERRCNT_EN
  output logic [7:0]  err_cnt_o,
`endif
  output logic        err_o
);

  logic [31:0] word;
  logic        wv, cs_fall, cs_rise;

  spi_word_deser #(.SYNC_STAGES(SYNC_STAGES)) u_deser (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .scs_i       (scs_i),
    .sck_i       (sck_i),
    .sdi_i       (sdi_i),
    .word_o      (word),
    .word_valid_o(wv),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise)
  );

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_q, req_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        abort_q, abort_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    req_d   = req_q;
    err_d   = 1'b0;
    ovr_d   = ovr_q;
    abort_d = abort_q;
    case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wv) begin
          if (word[OPC_HI:OPC_LO] == OP_WRITE && word[CNT_HI:CNT_LO] != '0) begin
            count_d = word[CNT_HI:CNT_LO];
            state_d = ADDR;
          end else begin
            err_d   = 1'b1;
            state_d = DRAIN;
          end
        end
      end
      ADDR: begin
        if (cs_rise) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (wv) begin
          addr_d  = {word[31:2], 2'b00};
          state_d = DATA;
        end
      end
      DATA: begin
        if (cs_rise) begin
          err_d   = (count_q != '0);
          state_d = IDLE;
        end else if (wv) begin
          wdata_d = word;
          req_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Chip-select loss and overrun are remembered until the pending write is granted
        if (cs_rise) abort_d = 1'b1;
        if (wv && !bus_gnt_i) begin
          err_d = 1'b1;
          ovr_d = 1'b1;
        end
        if (bus_gnt_i) begin
          req_d   = 1'b0;
          addr_d  = addr_q + ADDR_STEP;
          count_d = count_q - 16'd1;
          ovr_d   = 1'b0;
          abort_d = 1'b0;
          if (cs_rise || abort_q) begin
            state_d = IDLE;
          end else if (ovr_q || count_q == 16'd1) begin
            state_d = DRAIN;
          end else if (wv) begin
            wdata_d = word;
            req_d   = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DRAIN: if (cs_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      abort_q <= abort_d;
    end
  end

`ifdef SPI_CMD_CTRL_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_q && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

  assign bus_req_o   = req_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
  assign state_o     = state_q;

endmodule
